// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: IDLE/BUSY/DONE handshake, stalling the pipeline for LATENCY+1 cycles per access.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned or below-base addresses through mem_err.
module data_mem_responder #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 64,
    parameter int LATENCY  = 2,
    parameter int MEM_BASE = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic [WORD_LEN-1:0] ALU_res_MEM,
    input  logic [WORD_LEN-1:0] ST_value,
    output logic                mem_stall,
    output logic [WORD_LEN-1:0] rd_data,
    output logic                rd_valid,
    output logic                mem_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [WORD_LEN-1:0] cap_addr;
    logic [WORD_LEN-1:0] cap_data;
    logic                cap_rd;
    logic                cap_wr;
    logic [WORD_LEN-1:0] mem [DEPTH];

    logic                req;
    logic [WORD_LEN-1:0] offset;
    logic [AW-1:0]       idx;
    logic                addr_bad;
    logic                access;
    logic                mem_we;

    assign req       = MEM_R_EN | MEM_W_EN;
    assign mem_stall = rst & (((state == IDLE) & req) | (state == BUSY));
    assign offset    = cap_addr - WORD_LEN'(MEM_BASE);
    assign idx       = AW'(offset >> 2);
    assign access    = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_bad = (cap_addr[1:0] != 2'b00) || (cap_addr < WORD_LEN'(MEM_BASE));
`else
    assign addr_bad = 1'b0;
`endif

    // Gated by rst so a reset landing on the final BUSY cycle aborts the store.
    assign mem_we = rst && access && cap_wr && !addr_bad;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= cap_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            mem_err  <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_rd   <= 1'b0;
            cap_wr   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_addr <= ALU_res_MEM;
                        cap_data <= ST_value;
                        cap_rd   <= MEM_R_EN;
                        cap_wr   <= MEM_W_EN;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        if ((cap_rd && cap_wr) || addr_bad)
                            mem_err <= 1'b1;
                        // A simultaneous read+write resolves as a write only.
                        if (cap_rd && !cap_wr) begin
                            rd_valid <= 1'b1;
                            rd_data  <= addr_bad ? '0 : mem[idx];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected read data queued at request time, compared on each rd_valid strobe.
module tb_data_mem_responder;

    localparam int WL      = 32;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;
    localparam int BASE    = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          MEM_R_EN = 1'b0;
    logic          MEM_W_EN = 1'b0;
    logic [WL-1:0] ALU_res_MEM = '0;
    logic [WL-1:0] ST_value = '0;
    logic          mem_stall;
    logic [WL-1:0] rd_data;
    logic          rd_valid;
    logic          mem_err;

    int            total = 0;
    int            bad = 0;
    int            rd_count = 0;
    int            c0;
    logic [WL-1:0] exp_q[$];
    logic [WL-1:0] model [DEPTH];

    data_mem_responder #(
        .WORD_LEN(WL), .DEPTH(DEPTH), .LATENCY(LATENCY), .MEM_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_res_MEM(ALU_res_MEM), .ST_value(ST_value), .mem_stall(mem_stall),
        .rd_data(rd_data), .rd_valid(rd_valid), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [WL-1:0] got, input logic [WL-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [WL-1:0] a);
        logic [WL-1:0] off;
        off = (a - WL'(BASE)) >> 2;
        return int'(off % DEPTH);
    endfunction

    function automatic bit misaligned(input logic [WL-1:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00) || (a < WL'(BASE));
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst && rd_valid) begin
            rd_count++;
            if (exp_q.size() == 0)
                check_output("unexpected_rd_valid", 1, 0);
            else
                check_output("rd_data", rd_data, exp_q.pop_front());
        end
    end

    // Drives one request and counts stall cycles; returns during the DONE cycle.
    task automatic apply_stimulus(input logic r, input logic w, input logic [WL-1:0] a,
                                  input logic [WL-1:0] d, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        MEM_R_EN = r;
        MEM_W_EN = w;
        ALU_res_MEM = a;
        ST_value = d;
        if (r && !w)
            exp_q.push_back(misaligned(a) ? '0 : model[widx(a)]);
        if (w && !misaligned(a))
            model[widx(a)] = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!mem_stall) break;
            n++;
            @(negedge clk);
        end
        check_output("stall_cycles", n, LATENCY + 1);
        if (!hold) begin
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset values and stall suppression while in reset
        repeat (2) @(negedge clk);
        MEM_R_EN = 1'b1;
        #1;
        check_output("reset_stall", mem_stall, 0);
        check_output("reset_rd_valid", rd_valid, 0);
        check_output("reset_rd_data", rd_data, 0);
        check_output("reset_mem_err", mem_err, 0);
        @(negedge clk);
        rst = 1'b1;
        MEM_R_EN = 1'b0;

        // Basic write then read
        c0 = rd_count;
        apply_stimulus(0, 1, 1024, 32'hDEADBEEF, 0);
        apply_stimulus(1, 0, 1024, 0, 0);
        check_output("rd_pulses_basic", rd_count - c0, 1);
        @(negedge clk);
        check_output("rd_valid_drops", rd_valid, 0);
        check_output("rd_data_holds", rd_data, 32'hDEADBEEF);

        // Back-to-back reads with req held through DONE
        apply_stimulus(0, 1, 1028, 32'h11111111, 0);
        apply_stimulus(0, 1, 1032, 32'h22222222, 0);
        c0 = rd_count;
        apply_stimulus(1, 0, 1028, 0, 1);
        apply_stimulus(1, 0, 1032, 0, 0);
        check_output("rd_pulses_b2b", rd_count - c0, 2);

        // Index wrap-around modulo DEPTH
        apply_stimulus(0, 1, 1024 + 4 * DEPTH, 32'h1, 0);
        apply_stimulus(1, 0, 1024, 0, 0);

        // Reset during the second BUSY cycle aborts the write
        apply_stimulus(0, 1, 1040, 32'h1234, 0);
        @(negedge clk);
        MEM_W_EN = 1'b1;
        ALU_res_MEM = 1040;
        ST_value = 32'h55;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("stall_in_reset", mem_stall, 0);
        @(negedge clk);
        check_output("stall_in_reset_held", mem_stall, 0);
        rst = 1'b1;
        MEM_W_EN = 1'b0;
        apply_stimulus(1, 0, 1040, 0, 0);
        check_output("err_after_abort", mem_err, 0);

        // Misaligned write
        apply_stimulus(0, 1, 1025, 32'hA5A5A5A5, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        check_output("err_misaligned", mem_err, 1);
`else
        check_output("err_misaligned", mem_err, 0);
`endif
        apply_stimulus(1, 0, 1024, 0, 0);
        pulse_reset();
        #1;
        check_output("err_cleared", mem_err, 0);

        // Simultaneous read+write: write wins, sticky error, no strobe
        c0 = rd_count;
        apply_stimulus(1, 1, 1044, 32'h7, 0);
        check_output("rd_pulses_rw", rd_count - c0, 0);
        check_output("err_rw", mem_err, 1);
        apply_stimulus(1, 0, 1044, 0, 0);
        check_output("err_sticky", mem_err, 1);
        pulse_reset();
        #1;
        check_output("err_reset", mem_err, 0);
        apply_stimulus(1, 0, 1044, 0, 0);

        repeat (3) @(negedge clk);
        check_output("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, 64, number of WORD_LEN-bit words in the array (power of two).
REQ-002 Parameter LATENCY, 2, BUSY cycles per access (legal range 1..15).
REQ-003 Parameter MEM_BASE, 1024, byte address of word 0.
REQ-004 clk  in  1  single clock, all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 MEM_R_EN  in  1  read request from the MEM stage.
REQ-007 MEM_W_EN  in  1  write request from the MEM stage.
REQ-008 ALU_res_MEM  in  WORD_LEN  byte address.
REQ-009 ST_value  in  WORD_LEN  store data.
REQ-010 mem_stall  out  1  freeze request to the pipeline; the MEM stage holds its inputs while high.
REQ-011 rd_data  out  WORD_LEN  read data, valid only while rd_valid is high.
REQ-012 rd_valid  out  1  one-cycle read completion strobe.
REQ-013 mem_err  out  1  sticky error flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 A request is req = MEM_R_EN | MEM_W_EN.
REQ-016 In IDLE with req=1, the block SHALL capture address, data and op, load cnt = LATENCY-1, and go to BUSY.
REQ-017 In BUSY with cnt!=0, the block SHALL decrement cnt. In BUSY with cnt==0, it SHALL perform the access and go to DONE.
REQ-018 DONE SHALL return to IDLE unconditionally after one cycle. A req seen in DONE SHALL NOT be captured.
REQ-019 mem_stall SHALL equal (IDLE & req) | BUSY, combinationally, so the pipeline stalls for exactly LATENCY+1 cycles per access.
REQ-020 In DONE, mem_stall SHALL be 0, which lets the pipeline advance exactly once.
REQ-021 Word index SHALL be ((addr - MEM_BASE) >> 2), truncated to log2(DEPTH) bits; wrap-around modulo DEPTH is required.
REQ-022 Writes SHALL commit to the array only on the BUSY->DONE edge.
REQ-023 Reads SHALL sample the array on the BUSY->DONE edge. rd_data and rd_valid=1 SHALL be presented during DONE.
REQ-024 Outside DONE-after-read, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-025 If MEM_R_EN and MEM_W_EN are both captured, the write SHALL win, no read strobe SHALL be issued, and mem_err SHALL be set.
REQ-026 Inputs changing during BUSY SHALL have no effect on the access in flight.
REQ-027 A read to an index written in the immediately preceding access SHALL return the new data (no bypass hazard).

Reset
REQ-028 With rst=0 at a posedge: state=IDLE, cnt=0, rd_valid=0, rd_data=0, mem_err=0.
REQ-029 mem_stall SHALL be 0 while rst=0, regardless of req.
REQ-030 Reset during BUSY SHALL abort the access; no array write SHALL occur.
REQ-031 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro DMEM_ALIGN_CHECK_EN selects the alignment check.
REQ-033 With DMEM_ALIGN_CHECK_EN defined, a captured request with addr[1:0]!=0 or addr<MEM_BASE SHALL set mem_err and suppress the write. Such a read SHALL still complete with rd_data=0 and the normal latency.
REQ-034 Without DMEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored, and mem_err SHALL be driven only by REQ-025.

Verification
REQ-035 Write 0xDEADBEEF to 1024, then read 1024 (LATENCY=2) -> mem_stall high 3 cycles per access; rd_valid pulses once with 0xDEADBEEF.
REQ-036 Back-to-back reads to 1028 and 1032 holding req high -> two separate 3-cycle stalls separated by one stall-low DONE cycle; two rd_valid pulses.
REQ-037 Write 0x1 to 1024+4*DEPTH, then read 1024 -> returns 0x1 (wrap).
REQ-038 rst=0 in 2nd BUSY cycle of write 0x55 to 1040; then read 1040 -> old value returned; mem_stall 0 during reset.
REQ-039 MEM_R_EN=MEM_W_EN=1, write 0x7 to 1044 -> no rd_valid; mem_err=1 until reset; read 1044 returns 0x7.
REQ-040 DMEM_ALIGN_CHECK_EN defined, write to 1025 -> mem_err=1, array unchanged; same test without the macro -> write lands at word 0, mem_err=0.
